safe_access_ctrl: RTL
=====================

SAFE_ACCESS_CTRL -- requirements
Module: safe_access_ctrl

Interface
REQ-001 Parameter CODE_LEN, default 3: digits per combination (2..8).
REQ-002 Parameter MAX_FAIL, default 3: consecutive failures that trigger lockout (1..15).
REQ-003 Parameter T_OPEN, default 250_000_000: OPEN duration in clk cycles (5 s at 50 MHz).
REQ-004 Parameter T_ERR, default 150_000_000: ERROR duration in clk cycles (3 s).
REQ-005 Parameter T_LOCK, default 1_500_000_000: LOCKOUT duration in clk cycles (30 s).
REQ-006 clk  in  1  system clock, 50 MHz, all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 key_valid  in  1  single-cycle pulse: one digit entered (already synchronised and edge-detected upstream).
REQ-009 key_digit  in  2  digit value 0..3, sampled only when key_valid=1.
REQ-010 prog_req  in  1  single-cycle pulse: request code reprogramming.
REQ-011 led_green  out  8  entry progress / open indication.
REQ-012 led_red  out  1  error or lockout indication.
REQ-013 locked  out  1  high while in LOCKOUT.
REQ-014 fail_cnt  out  4  current consecutive-failure count.
REQ-015 prog_active  out  1  high while in PROG.

Function
REQ-016 States: ENTRY, OPEN, ERROR, LOCKOUT, PROG; state register and idx (digit index, 0..CODE_LEN-1) are registered.
REQ-017 ENTRY: key_valid with key_digit==code[idx] increments idx; on last digit (idx==CODE_LEN-1) go to OPEN, idx<=0.
REQ-018 ENTRY: key_valid with wrong digit -> ERROR immediately, idx<=0, fail_cnt<=fail_cnt+1 (saturating at 15).
REQ-019 Wrong digit making fail_cnt reach MAX_FAIL -> LOCKOUT instead of ERROR.
REQ-020 Entering OPEN clears fail_cnt to 0.
REQ-021 OPEN, ERROR, LOCKOUT each last exactly their T_* cycles from the first cycle in the state, then return to ENTRY with idx=0.
REQ-022 Leaving LOCKOUT clears fail_cnt to 0.
REQ-023 key_valid ignored in OPEN, ERROR, LOCKOUT; no counter or index effect.
REQ-024 OPEN with prog_req -> PROG next cycle (timer abandoned); prog_req ignored in all other states.
REQ-025 PROG: each key_valid writes key_digit into new-code slot idx; after CODE_LEN digits code register is replaced atomically and state -> ENTRY.
REQ-026 PROG has no timeout; partial new code never affects code register.
REQ-027 Simultaneous prog_req and OPEN timer expiry: prog_req wins.
REQ-028 Latency: state/output change visible in cycle after the key_valid/prog_req/expiry cycle.
REQ-029 led_green: ENTRY = thermometer of (idx+1) LSBs; OPEN = 8'hFF; PROG = 8'hAA; else 0.
REQ-030 led_red = 1 in ERROR and LOCKOUT; locked = 1 only in LOCKOUT.

Reset
REQ-031 rst (async) forces state=ENTRY, idx=0, fail_cnt=0, timer=0, code=default {0,1,2,...} (digit i = i mod 4).
REQ-032 Reset outputs: led_green=8'h01, led_red=0, locked=0, fail_cnt=0, prog_active=0.
REQ-033 Reset mid-PROG discards partial code and restores default code.

Configuration
REQ-034 Macro SAFE_PROG_EN: defined -> PROG state and programmable code register present.
REQ-035 SAFE_PROG_EN undefined -> code is constant default, prog_req ignored, prog_active tied 0, PROG state absent.

Structure
REQ-036 Package safe_pkg: state_t enum, digit_t (2-bit), DEFAULT_CODE function/constant, LED pattern constants.
REQ-037 Sub-module safe_timer: loadable down-counter (load value, load strobe, expired flag), width $clog2 of largest T_*; one instance shared by OPEN/ERROR/LOCKOUT.

Verification (bench params CODE_LEN=3, MAX_FAIL=3, T_OPEN=5, T_ERR=3, T_LOCK=8)
REQ-038 Digits 0,1,2 after reset -> OPEN cycle after third key, led_green=FF for 5 cycles, then ENTRY, led_green=01.
REQ-039 Digits 0,3 -> ERROR after second key, led_red=1 for 3 cycles, fail_cnt=1.
REQ-040 Three wrong first digits (waiting out ERRORs) -> third gives LOCKOUT, locked=1 for 8 cycles, keys ignored, fail_cnt=0 afterward.
REQ-041 Open, prog_req, digits 3,3,1 -> code 3,3,1; then 0,1,2 -> ERROR, 3,3,1 -> OPEN.
REQ-042 rst asserted mid-PROG after one digit -> ENTRY, default code 0,1,2 opens.
REQ-043 prog_req on OPEN expiry cycle -> PROG entered, prog_active=1.

Source files
------------

// File: rtl/safe_pkg.sv
// safe_pkg: shared types and constants for the safe access controller.
//   state_t          - controller states (PROG only when SAFE_PROG_EN is defined)
//   digit_t          - one keypad digit, values 0..3
//   LED_* constants  - fixed green LED patterns
//   default_digit()  - digit i of the factory code (i mod 4)
//   led_thermo()     - thermometer pattern with n LSBs lit
// Configuration macro: SAFE_PROG_EN.
package safe_pkg;

    typedef logic [1:0] digit_t;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_ERROR,
`ifdef SAFE_PROG_EN
        ST_LOCKOUT,
        ST_PROG
`else
        ST_LOCKOUT
`endif
    } state_t;

    localparam logic [7:0] LED_OFF  = 8'h00;
    localparam logic [7:0] LED_OPEN = 8'hFF;
    localparam logic [7:0] LED_PROG = 8'hAA;

    function automatic digit_t default_digit(input int i);
        return digit_t'(i % 4);
    endfunction

    function automatic logic [7:0] led_thermo(input int n);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i < n) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/safe_timer.sv
// safe_timer: loadable down-counter shared by the timed states.
//   clk, rst  - clock, asynchronous active-high reset (count -> 0)
//   load      - load strobe, count takes load_val on the next edge
//   load_val  - value to load (duration minus one)
//   expired   - high while the count is zero
module safe_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/safe_access_ctrl.sv
// safe_access_ctrl: keypad combination lock with error/lockout timing and
// optional code reprogramming (enabled by macro SAFE_PROG_EN).
//   clk, rst     - clock, asynchronous active-high reset
//   key_valid    - one-cycle pulse, key_digit holds the entered digit
//   key_digit    - digit 0..3
//   prog_req     - one-cycle pulse, requests reprogramming while OPEN
//   led_green    - entry progress thermometer / FF open / AA programming
//   led_red      - high in ERROR and LOCKOUT
//   locked       - high in LOCKOUT
//   fail_cnt     - consecutive failed attempts
//   prog_active  - high in PROG
module safe_access_ctrl
    import safe_pkg::*;
#(
    parameter int CODE_LEN = 3,
    parameter int MAX_FAIL = 3,
    parameter int T_OPEN   = 250_000_000,
    parameter int T_ERR    = 150_000_000,
    parameter int T_LOCK   = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       prog_req,
    output logic [7:0] led_green,
    output logic       led_red,
    output logic       locked,
    output logic [3:0] fail_cnt,
    output logic       prog_active
);

    localparam int T_MAX = (T_LOCK > T_OPEN) ? ((T_LOCK > T_ERR) ? T_LOCK : T_ERR)
                                             : ((T_OPEN > T_ERR) ? T_OPEN : T_ERR);
    localparam int TW = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [3:0]    fail_n, fail_inc;
    logic          key_ok, last_digit, commit;
    logic          tmr_load, tmr_expired;
    logic [TW-1:0] tmr_val;
    digit_t        code [CODE_LEN];

`ifdef SAFE_PROG_EN
    digit_t        new_code [CODE_LEN];

    // Staging buffer needs no reset: every slot is rewritten before a commit.
    always_ff @(posedge clk) begin
        if (state == ST_PROG && key_valid) new_code[idx] <= key_digit;
    end
`else
    logic unused_prog;
    assign unused_prog = prog_req;

    for (genvar g = 0; g < CODE_LEN; g++) begin : g_const_code
        assign code[g] = default_digit(g);
    end
    assign prog_active = 1'b0;
`endif

    assign key_ok     = (key_digit == code[idx]);
    assign last_digit = (idx == IW'(CODE_LEN - 1));
    assign fail_inc   = (fail_cnt == 4'd15) ? 4'd15 : fail_cnt + 4'd1;

    safe_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Timed states are only ever entered from ENTRY on a key, so the timer
    // is loaded with the duration of whichever state that key selects.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        fail_n   = fail_cnt;
        tmr_load = 1'b0;
        tmr_val  = '0;
        commit   = 1'b0;
        case (state)
            ST_ENTRY: begin
                if (key_valid) begin
                    tmr_load = 1'b1;
                    idx_n    = '0;
                    if (key_ok && last_digit) begin
                        state_n = ST_OPEN;
                        fail_n  = 4'd0;
                        tmr_val = TW'(T_OPEN - 1);
                    end else if (key_ok) begin
                        idx_n = idx + 1'b1;
                    end else begin
                        fail_n = fail_inc;
                        if (fail_inc >= 4'(MAX_FAIL)) begin
                            state_n = ST_LOCKOUT;
                            tmr_val = TW'(T_LOCK - 1);
                        end else begin
                            state_n = ST_ERROR;
                            tmr_val = TW'(T_ERR - 1);
                        end
                    end
                end
            end
            ST_OPEN: begin
`ifdef SAFE_PROG_EN
                // A programming request beats a simultaneous timer expiry.
                if (prog_req) begin
                    state_n = ST_PROG;
                    idx_n   = '0;
                end else
`endif
                if (tmr_expired) begin
                    state_n = ST_ENTRY;
                    idx_n   = '0;
                end
            end
            ST_ERROR: begin
                if (tmr_expired) begin
                    state_n = ST_ENTRY;
                    idx_n   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_expired) begin
                    state_n = ST_ENTRY;
                    idx_n   = '0;
                    fail_n  = 4'd0;
                end
            end
`ifdef SAFE_PROG_EN
            ST_PROG: begin
                if (key_valid) begin
                    if (last_digit) begin
                        state_n = ST_ENTRY;
                        idx_n   = '0;
                        commit  = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_n = ST_ENTRY;
                idx_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change together
    // with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ENTRY;
            idx       <= '0;
            fail_cnt  <= 4'd0;
            led_green <= 8'h01;
            led_red   <= 1'b0;
            locked    <= 1'b0;
`ifdef SAFE_PROG_EN
            prog_active <= 1'b0;
            for (int i = 0; i < CODE_LEN; i++) code[i] <= default_digit(i);
`endif
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            fail_cnt <= fail_n;
            led_red  <= (state_n == ST_ERROR) || (state_n == ST_LOCKOUT);
            locked   <= (state_n == ST_LOCKOUT);
            case (state_n)
                ST_ENTRY: led_green <= led_thermo(int'(idx_n) + 1);
                ST_OPEN:  led_green <= LED_OPEN;
`ifdef SAFE_PROG_EN
                ST_PROG:  led_green <= LED_PROG;
`endif
                default:  led_green <= LED_OFF;
            endcase
`ifdef SAFE_PROG_EN
            prog_active <= (state_n == ST_PROG);
            // Whole code replaced in one edge; the final digit bypasses the buffer.
            if (commit) begin
                for (int i = 0; i < CODE_LEN; i++)
                    code[i] <= (i == int'(idx)) ? key_digit : new_code[i];
            end
`endif
        end
    end

endmodule
